// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module  : if_fetch_stage
// Brief   : Instruction-fetch stage owning the PC, icache miss tracking and
//           branch redirects, feeding the IF/ID register.
//           Optional performance counters under macro IF_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_hit,
  input  logic        instruction_hit,
  input  logic [31:0] icache_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] icache_addr,
  output logic        icache_rd,
  output logic [31:0] npc,
  output logic [31:0] instr,
  output logic        valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] miss_cycles
`endif
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_pend;
  logic        w_pend_nxt;
  logic [31:0] r_pend_target;
  logic [31:0] w_pend_target_nxt;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;
  logic        w_valid;
  logic        w_unused_target_lsb;

  assign w_target            = {branch_target[31:2], 2'b00};
  assign w_unused_target_lsb = ^branch_target[1:0];
  assign w_pc_inc            = r_pc + 32'd4;

  assign icache_addr = r_pc;
  assign icache_rd   = ~rst;
  assign npc         = w_pc_inc;
  assign valid       = w_valid;
  assign instr       = w_valid ? icache_data : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_pend        <= 1'b0;
      r_pend_target <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pend_nxt        = r_pend;
    w_pend_target_nxt = r_pend_target;
    w_valid           = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_valid = ~rst & instruction_hit & ~branch_taken;
        if (branch_taken) begin
          w_pc_nxt = w_target;
        end else if (!instruction_hit) begin
          w_state_nxt = ST_MISS;
        end else if (data_hit) begin
          w_pc_nxt = w_pc_inc;
        end
      end
      ST_MISS: begin
        // A redirect seen during the miss squashes the word that finally returns.
        w_valid = ~rst & instruction_hit & ~branch_taken & ~r_pend;
        if (instruction_hit) begin
          if (branch_taken) begin
            w_pc_nxt = w_target;
          end else if (r_pend) begin
            w_pc_nxt = r_pend_target;
          end else if (data_hit) begin
            w_pc_nxt = w_pc_inc;
          end
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_RUN;
        end else if (branch_taken) begin
          w_pend_nxt        = 1'b1;
          w_pend_target_nxt = w_target;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_miss_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt   <= 32'd0;
      r_miss_cycles <= 32'd0;
    end else begin
      if (w_valid && data_hit) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (r_state == ST_MISS) begin
        r_miss_cycles <= r_miss_cycles + 32'd1;
      end
    end
  end

  assign fetch_cnt   = r_fetch_cnt;
  assign miss_cycles = r_miss_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module  : tb_if_fetch_stage
// Brief   : Self-checking bench for if_fetch_stage: directed scenarios plus
//           randomized traffic against a cycle-level behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0100;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_hit;
  logic        instruction_hit;
  logic [31:0] icache_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] icache_addr;
  logic        icache_rd;
  logic [31:0] npc;
  logic [31:0] instr;
  logic        valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] miss_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: where the fetcher is, whether it waits on the icache,
  // and which redirect (if any) it owes once the outstanding fetch returns.
  logic [31:0] m_pc;
  bit          m_waiting;
  bit          m_owes_redirect;
  logic [31:0] m_owed_target;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_miss_cnt;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC (C_RESET_PC),
    .NOP_INSTR(C_NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_hit       (data_hit),
    .instruction_hit(instruction_hit),
    .icache_data    (icache_data),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .icache_addr    (icache_addr),
    .icache_rd      (icache_rd),
    .npc            (npc),
    .instr          (instr),
    .valid          (valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .miss_cycles    (miss_cycles)
`endif
  );

  function automatic logic m_valid();
    if (rst) return 1'b0;
    return instruction_hit && !branch_taken && !(m_waiting && m_owes_redirect);
  endfunction

  task automatic model_step();
    logic [31:0] tgt;
    tgt = branch_target & 32'hFFFF_FFFC;
    if (rst) begin
      m_pc = C_RESET_PC; m_waiting = 0; m_owes_redirect = 0; m_owed_target = 0;
      m_fetch_cnt = 0; m_miss_cnt = 0;
      return;
    end
    if (m_valid() && data_hit) m_fetch_cnt++;
    if (m_waiting) m_miss_cnt++;
    if (!m_waiting) begin
      if (branch_taken)          m_pc = tgt;
      else if (!instruction_hit) m_waiting = 1;
      else if (data_hit)         m_pc = m_pc + 4;
    end else if (instruction_hit) begin
      if (branch_taken)         m_pc = tgt;
      else if (m_owes_redirect) m_pc = m_owed_target;
      else if (data_hit)        m_pc = m_pc + 4;
      m_owes_redirect = 0;
      m_waiting = 0;
    end else if (branch_taken) begin
      m_owes_redirect = 1;
      m_owed_target = tgt;
    end
  endtask

  task automatic set_in(input logic r, input logic dh, input logic ih, input logic bt,
                        input logic [31:0] tgt, input logic [31:0] data);
    rst = r; data_hit = dh; instruction_hit = ih; branch_taken = bt;
    branch_target = tgt; icache_data = data;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Stimulus only: a redirect from RUN, landing on tgt next cycle.
  task automatic redirect(input logic [31:0] tgt);
    set_in(0, 1, 1, 1, tgt, $urandom);
    step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 1, 0, 32'h0, $urandom);
      @(negedge clk);
      n_cmp++;
      if ({icache_addr, valid, icache_rd, instr} !== {C_RESET_PC, 1'b0, 1'b0, C_NOP}) begin
        n_err++;
        $display("FAIL reset[%0d]: got addr=%h valid=%b rd=%b instr=%h, want addr=%h valid=0 rd=0 instr=%h",
                 i, icache_addr, valid, icache_rd, instr, C_RESET_PC, C_NOP);
      end
      step();
    end
    set_in(0, 1, 1, 0, 32'h0, $urandom);
    @(negedge clk);
    n_cmp++;
    if ({icache_addr, icache_rd, valid} !== {C_RESET_PC, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL reset_release: got addr=%h rd=%b valid=%b, want addr=%h rd=1 valid=1",
               icache_addr, icache_rd, valid, C_RESET_PC);
    end
    step();
  endtask

  task automatic test_sequential();
    logic [31:0] d;
    redirect(32'h0);
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      set_in(0, 1, 1, 0, 32'h0, d);
      @(negedge clk);
      n_cmp++;
      if ({icache_addr, npc, valid, instr} !== {32'(4 * i), 32'(4 * i + 4), 1'b1, d}) begin
        n_err++;
        $display("FAIL seq[%0d]: got addr=%h npc=%h valid=%b instr=%h, want addr=%h npc=%h valid=1 instr=%h",
                 i, icache_addr, npc, valid, instr, 4 * i, 4 * i + 4, d);
      end
      step();
    end
  endtask

  task automatic test_data_stall();
    redirect(32'h8);
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 1, 0, 32'h0, $urandom);
      @(negedge clk);
      n_cmp++;
      if ({icache_addr, npc, valid} !== {32'h8, 32'hC, 1'b1}) begin
        n_err++;
        $display("FAIL stall[%0d]: got addr=%h npc=%h valid=%b, want addr=8 npc=c valid=1",
                 i, icache_addr, npc, valid);
      end
      step();
    end
    set_in(0, 1, 1, 0, 32'h0, $urandom);
    step();
    @(negedge clk);
    n_cmp++;
    if (icache_addr !== 32'hC) begin
      n_err++;
      $display("FAIL stall_release: got addr=%h, want addr=c", icache_addr);
    end
    step();
  endtask

  task automatic test_miss();
    logic [31:0] d;
    redirect(32'h10);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 0, 32'h0, $urandom);
      @(negedge clk);
      n_cmp++;
      if ({icache_addr, valid, instr} !== {32'h10, 1'b0, C_NOP}) begin
        n_err++;
        $display("FAIL miss[%0d]: got addr=%h valid=%b instr=%h, want addr=10 valid=0 instr=%h",
                 i, icache_addr, valid, instr, C_NOP);
      end
      step();
    end
    d = $urandom;
    set_in(0, 1, 1, 0, 32'h0, d);
    @(negedge clk);
    n_cmp++;
    if ({valid, npc, instr} !== {1'b1, 32'h14, d}) begin
      n_err++;
      $display("FAIL miss_hit: got valid=%b npc=%h instr=%h, want valid=1 npc=14 instr=%h",
               valid, npc, instr, d);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (icache_addr !== 32'h14) begin
      n_err++;
      $display("FAIL miss_next: got addr=%h, want addr=14", icache_addr);
    end
`ifdef IF_PERF_CNT_EN
    n_cmp++;
    if (miss_cycles !== 32'd3) begin
      n_err++;
      $display("FAIL miss_cycles: got %0d, want 3", miss_cycles);
    end
`endif
    step();
  endtask

  task automatic test_redirect();
    redirect(32'h30);
    set_in(0, 1, 0, 0, 32'h0, $urandom);
    step();
    set_in(0, 1, 0, 0, 32'h0, $urandom);
    step();
    set_in(0, 1, 0, 1, 32'h43, $urandom);
    step();
    set_in(0, 1, 1, 0, 32'h0, $urandom);
    @(negedge clk);
    n_cmp++;
    if ({valid, icache_addr} !== {1'b0, 32'h30}) begin
      n_err++;
      $display("FAIL miss_redirect_hit: got valid=%b addr=%h, want valid=0 addr=30", valid, icache_addr);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (icache_addr !== 32'h40) begin
      n_err++;
      $display("FAIL miss_redirect_next: got addr=%h, want addr=40", icache_addr);
    end
    step();
    redirect(32'h20);
    set_in(0, 1, 1, 1, 32'h80, $urandom);
    @(negedge clk);
    n_cmp++;
    if ({valid, icache_addr, instr} !== {1'b0, 32'h20, C_NOP}) begin
      n_err++;
      $display("FAIL run_redirect: got valid=%b addr=%h instr=%h, want valid=0 addr=20 instr=%h",
               valid, icache_addr, instr, C_NOP);
    end
    step();
    set_in(0, 1, 1, 0, 32'h0, $urandom);
    @(negedge clk);
    n_cmp++;
    if (icache_addr !== 32'h80) begin
      n_err++;
      $display("FAIL run_redirect_next: got addr=%h, want addr=80", icache_addr);
    end
    step();
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    set_in(0, 1, 1, 0, 32'h0, $urandom);
    @(negedge clk);
    n_cmp++;
    if ({npc, valid} !== {32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL wrap_npc: got npc=%h valid=%b, want npc=0 valid=1", npc, valid);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (icache_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_next: got addr=%h, want addr=0", icache_addr);
    end
    step();
  endtask

  task automatic test_reset_mid_miss();
    set_in(0, 1, 0, 0, 32'h0, $urandom);
    step();
    set_in(0, 1, 0, 1, 32'h200, $urandom);
    step();
    set_in(1, 1, 0, 0, 32'h0, $urandom);
    step();
    set_in(0, 1, 1, 0, 32'h0, $urandom);
    @(negedge clk);
    n_cmp++;
    if ({icache_addr, valid} !== {C_RESET_PC, 1'b1}) begin
      n_err++;
      $display("FAIL rst_miss: got addr=%h valid=%b, want addr=%h valid=1", icache_addr, valid, C_RESET_PC);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (icache_addr !== C_RESET_PC + 32'd4) begin
      n_err++;
      $display("FAIL rst_miss_next: got addr=%h, want addr=%h", icache_addr, C_RESET_PC + 32'd4);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic        ev;
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      set_in(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 5) == 0), $urandom, d);
      @(negedge clk);
      ev = m_valid();
      n_cmp++;
      if ({icache_addr, npc, valid, instr, icache_rd} !==
          {m_pc, m_pc + 32'd4, ev, (ev ? d : C_NOP), ~rst}) begin
        n_err++;
        $display("FAIL rand[%0d]: got addr=%h npc=%h valid=%b instr=%h rd=%b, want addr=%h npc=%h valid=%b instr=%h rd=%b",
                 i, icache_addr, npc, valid, instr, icache_rd,
                 m_pc, m_pc + 32'd4, ev, (ev ? d : C_NOP), ~rst);
      end
`ifdef IF_PERF_CNT_EN
      n_cmp++;
      if ({fetch_cnt, miss_cycles} !== {m_fetch_cnt, m_miss_cnt}) begin
        n_err++;
        $display("FAIL rand_cnt[%0d]: got fetch=%0d miss=%0d, want fetch=%0d miss=%0d",
                 i, fetch_cnt, miss_cycles, m_fetch_cnt, m_miss_cnt);
      end
`endif
      step();
    end
  endtask

  initial begin
    m_pc = C_RESET_PC; m_waiting = 0; m_owes_redirect = 0; m_owed_target = 0;
    m_fetch_cnt = 0; m_miss_cnt = 0;
    test_reset();
    test_sequential();
    test_data_stall();
    test_miss();
    test_redirect();
    test_wrap();
    test_reset_mid_miss();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter and drives the instruction-cache address. It tracks instruction-cache misses and data-side stalls through a small FSM and accepts branch redirects from later stages. It presents npc/instr/valid to IF/ID, using the same data_hit / instruction_hit stall semantics as IF/ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
NOP_INSTR, 32'h0000_0000, instruction word driven on instr when valid=0

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
data_hit  input  1  0 = data cache stalling the pipeline; PC must hold
instruction_hit  input  1  1 = icache_data valid for icache_addr this cycle
icache_data  input  32  instruction word from the instruction cache
branch_taken  input  1  redirect request from a later stage
branch_target  input  32  redirect address, bits [1:0] ignored
icache_addr  output  32  fetch address, always equal to the current PC
icache_rd  output  1  fetch request
npc  output  32  PC+4 of the instruction on instr, to IF/ID npc
instr  output  32  fetched instruction, to IF/ID instr
valid  output  1  instr/npc hold a real, non-squashed instruction

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. rst has priority over every other input.
- Reset values:
  - pc = RESET_PC, state = RUN, pend = 0, pend_target = 0.
  - icache_rd = 0 while rst = 1, and 1 otherwise.
  - valid = 0.
- Combinational outputs:
  - icache_addr = pc.
  - npc = pc + 4, mod 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
  - instr = icache_data when valid = 1, else NOP_INSTR.
- Redirect address: the loaded value is always {branch_target[31:2], 2'b00}.
- State RUN, valid = instruction_hit & ~branch_taken:
  - branch_taken = 1: pc <= target, stay RUN. The current fetch is squashed (valid = 0), whatever data_hit and instruction_hit are.
  - instruction_hit = 0: pc holds, go to MISS.
  - instruction_hit = 1, data_hit = 0: pc holds, valid = 1. The same instruction is re-presented next cycle and IF/ID is holding it.
  - instruction_hit = 1, data_hit = 1: pc <= pc + 4.
- State MISS, valid = 0 except on a clean hit:
  - pc holds throughout the miss.
  - branch_taken = 1 while instruction_hit = 0: pend <= 1, pend_target <= target. A later redirect overwrites an earlier one.
  - instruction_hit = 1 with pend = 1 or branch_taken = 1: valid = 0 and the returned word is discarded. pc <= target, where branch_taken this cycle beats pend_target. Clear pend, go to RUN.
  - instruction_hit = 1, no redirect pending or arriving: valid = 1. pc <= pc + 4 if data_hit = 1, else hold. Go to RUN.
- No valid instruction is ever produced from a fetch that began before a redirect.
- Reset mid-miss: pend and pend_target are cleared, pc = RESET_PC, state = RUN on the next edge.
- Latency: a hit delivers its instruction on instr in the same cycle its address is on icache_addr. The next sequential address appears one cycle later.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, two extra outputs are added, both reset to 0 by rst:
  - fetch_cnt, 32 bits: increments on every cycle with valid = 1 and data_hit = 1.
  - miss_cycles, 32 bits: increments on every cycle in state MISS.
  - Both counters wrap at 2^32.
- When undefined, the ports and the counter logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst = 1 for 2 cycles with RESET_PC = 0x100 -> icache_addr = 0x100, valid = 0, icache_rd = 0. After release, icache_rd = 1.
- Sequential hits: instruction_hit = 1, data_hit = 1 for 3 cycles from pc 0 -> icache_addr 0, 4, 8 and npc 4, 8, 12, each with valid = 1 and instr = icache_data.
- Data stall: data_hit = 0 for 2 cycles at pc 8 with a hit -> icache_addr stays 8, valid = 1, npc = 12. After data_hit = 1, advances to 0xC.
- Miss: instruction_hit = 0 for 3 cycles at pc 0x10 -> addr holds 0x10, valid = 0, instr = NOP_INSTR. On the hit cycle, valid = 1 and npc = 0x14; next addr = 0x14.
- Redirect during miss: branch_taken with target 0x43 in miss cycle 2, then hit -> valid = 0 on the hit cycle, next icache_addr = 0x40. Also a redirect in RUN at pc 0x20 with target 0x80 -> valid = 0, next addr 0x80.
- Wrap and reset mid-miss: pc 0xFFFF_FFFC hit -> npc = 0, next addr 0. rst asserted during MISS with a pending redirect -> after reset, addr = RESET_PC and the pending target is never taken. With IF_PERF_CNT_EN defined, miss_cycles = 3 after the miss scenario.
